display_scroll_ctrl: RTL and testbench

//  Scroll controller for the 4-digit multiplexed 7-seg display. Holds a MSG_LEN x 4-bit

---
 rtl/disp_pkg.sv | 12 +
 rtl/scroll_tick_div.sv | 47 ++++
 rtl/display_scroll_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_display_scroll_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared display types and constants for the scroll controller and its divider.
package disp_pkg;

    localparam int         CHAR_W     = 4;
    localparam logic [3:0] CHAR_BLANK = 4'hF;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } scroll_state_t;

endpackage

// File: rtl/scroll_tick_div.sv
// Scroll-rate divider: counts 0..SCROLL_DIV-1 while enabled and flags the last count.
module scroll_tick_div #(
    parameter int DIV_W      = 26,
    parameter int SCROLL_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(SCROLL_DIV - 32'd1);
    localparam logic [DIV_W-1:0] ONE  = DIV_W'(1'b1);
    localparam logic [DIV_W-1:0] ZERO = {DIV_W{1'b0}};

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_nxt_s;

    // Next count: clear has priority, frozen when disabled.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = ZERO;
        end else if (en) begin
            if (cnt_r == LAST) begin
                cnt_nxt_s = ZERO;
            end else begin
                cnt_nxt_s = cnt_r + ONE;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= ZERO;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign tick = en & (cnt_r == LAST);

endmodule

// File: rtl/display_scroll_ctrl.sv
// Message buffer plus 4-char sliding window for the 7-seg digit mux.
// Optional macro SCROLL_BOUNCE_EN selects ping-pong scrolling instead of wrap-around.
module display_scroll_ctrl
    import disp_pkg::*;
#(
    parameter int MSG_LEN    = 16,
    parameter int ADDR_W     = 4,
    parameter int DIV_W      = 26,
    parameter int SCROLL_DIV = 25_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    output logic              busy,
    output logic [CHAR_W-1:0] char3,
    output logic [CHAR_W-1:0] char2,
    output logic [CHAR_W-1:0] char1,
    output logic [CHAR_W-1:0] char0,
    output logic [ADDR_W-1:0] pos,
    output logic              frame_strobe,
    output logic              wr_err
);

    localparam logic [ADDR_W-1:0] ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1'b1);
    localparam logic [ADDR_W-1:0] TWO   = ADDR_W'(2'd2);
    localparam logic [ADDR_W-1:0] THREE = ADDR_W'(2'd3);

    scroll_state_t     state_r;
    scroll_state_t     state_nxt_s;
    logic              run_s;
    logic              wr_ok_s;
    logic              tick_s;
    logic              pos_chg_s;
    logic              pos_chg_r;
    logic              strobe_r;
    logic              wr_err_r;
    logic [ADDR_W-1:0] pos_r;
    logic [ADDR_W-1:0] pos_nxt_s;
    logic [ADDR_W-1:0] idx1_s;
    logic [ADDR_W-1:0] idx2_s;
    logic [ADDR_W-1:0] idx3_s;
    logic [CHAR_W-1:0] buf_r [MSG_LEN];

    scroll_tick_div #(
        .DIV_W      (DIV_W),
        .SCROLL_DIV (SCROLL_DIV)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (run_s),
        .clr   (clear),
        .tick  (tick_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: stop dominates a simultaneous start.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start && !stop) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        run_s   = 1'b0;
        wr_ok_s = 1'b0;
        case (state_r)
            S_IDLE:  wr_ok_s = 1'b1;
            S_RUN:   run_s   = 1'b1;
            default: begin
                run_s   = 1'b0;
                wr_ok_s = 1'b0;
            end
        endcase
    end

`ifdef SCROLL_BOUNCE_EN
    localparam logic [ADDR_W-1:0] TOP = ADDR_W'(MSG_LEN - 32'd4);

    logic dir_r;
    logic dir_nxt_s;

    // Ping-pong position: the turn-around and the step happen on the same edge.
    always_comb begin
        pos_nxt_s = pos_r;
        dir_nxt_s = dir_r;
        if (clear) begin
            pos_nxt_s = ZERO;
            dir_nxt_s = 1'b0;
        end else if (tick_s) begin
            if (!dir_r) begin
                if (pos_r == TOP) begin
                    dir_nxt_s = 1'b1;
                    pos_nxt_s = pos_r - ONE;
                end else begin
                    pos_nxt_s = pos_r + ONE;
                end
            end else begin
                if (pos_r == ZERO) begin
                    dir_nxt_s = 1'b0;
                    pos_nxt_s = pos_r + ONE;
                end else begin
                    pos_nxt_s = pos_r - ONE;
                end
            end
        end else begin
            pos_nxt_s = pos_r;
        end
    end

    // Scroll direction register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_r <= 1'b0;
        end else begin
            dir_r <= dir_nxt_s;
        end
    end
`else
    // Wrap-around position: ADDR_W arithmetic wraps mod MSG_LEN.
    always_comb begin
        pos_nxt_s = pos_r;
        if (clear) begin
            pos_nxt_s = ZERO;
        end else if (tick_s) begin
            pos_nxt_s = pos_r + ONE;
        end else begin
            pos_nxt_s = pos_r;
        end
    end
`endif

    assign pos_chg_s = clear | tick_s;
    assign idx1_s    = pos_r + ONE;
    assign idx2_s    = pos_r + TWO;
    assign idx3_s    = pos_r + THREE;

    // Position and pulse flags; frame_strobe trails the pos change by the window latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_r     <= ZERO;
            pos_chg_r <= 1'b0;
            strobe_r  <= 1'b0;
            wr_err_r  <= 1'b0;
        end else begin
            pos_r     <= pos_nxt_s;
            pos_chg_r <= pos_chg_s;
            strobe_r  <= pos_chg_r;
            wr_err_r  <= wr_en & run_s;
        end
    end

    // Message buffer, writable only while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                buf_r[i] <= {CHAR_W{1'b0}};
            end
        end else if (wr_en && wr_ok_s) begin
            buf_r[wr_addr] <= wr_data;
        end
    end

    // Registered display window; char3 is the leftmost digit at pos.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            char3 <= {CHAR_W{1'b0}};
            char2 <= {CHAR_W{1'b0}};
            char1 <= {CHAR_W{1'b0}};
            char0 <= {CHAR_W{1'b0}};
        end else begin
            char3 <= buf_r[pos_r];
            char2 <= buf_r[idx1_s];
            char1 <= buf_r[idx2_s];
            char0 <= buf_r[idx3_s];
        end
    end

    assign busy         = run_s;
    assign pos          = pos_r;
    assign frame_strobe = strobe_r;
    assign wr_err       = wr_err_r;

endmodule

// File: tb/tb_display_scroll_ctrl.sv
// Randomized and directed bench for display_scroll_ctrl against a step-sequence model.
module tb_display_scroll_ctrl;

    localparam int MSG_LEN = 16;
    localparam int ADDR_W  = 4;
    localparam int DIV     = 4;
`ifdef SCROLL_BOUNCE_EN
    localparam int PERIOD  = 2 * (MSG_LEN - 4);
`else
    localparam int PERIOD  = MSG_LEN;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [3:0]  wr_data = 4'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic        busy, frame_strobe, wr_err;
    logic [3:0]  char3, char2, char1, char0, pos;
    logic [22:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // Model: step count since clear/reset, buffer, run flag, clocks spent running.
    logic [3:0]  m_buf [MSG_LEN];
    int          m_k, m_run, m_elapsed, m_changed;
    logic [22:0] exp_vec;

    always #5 clk = ~clk;

    display_scroll_ctrl #(
        .MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W), .DIV_W(26), .SCROLL_DIV(DIV)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .clear(clear), .busy(busy),
        .char3(char3), .char2(char2), .char1(char1), .char0(char0),
        .pos(pos), .frame_strobe(frame_strobe), .wr_err(wr_err)
    );

    assign dut_vec = {char3, char2, char1, char0, pos, busy, frame_strobe, wr_err};

    function automatic int pos_of(input int k);
`ifdef SCROLL_BOUNCE_EN
        return (k <= MSG_LEN - 4) ? k : PERIOD - k;
`else
        return k % MSG_LEN;
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < MSG_LEN; i++) m_buf[i] = 4'd0;
        m_k = 0; m_run = 0; m_elapsed = 0; m_changed = 0;
        exp_vec = 23'd0;
    endfunction

    function automatic void model_step();
        int p;
        logic [15:0] win;
        logic strobe, werr;
        p      = pos_of(m_k);
        win    = {m_buf[p], m_buf[(p + 1) % MSG_LEN], m_buf[(p + 2) % MSG_LEN], m_buf[(p + 3) % MSG_LEN]};
        strobe = (m_changed != 0);
        werr   = wr_en && (m_run != 0);
        m_changed = 0;
        if (clear) begin
            m_k = 0; m_elapsed = 0; m_changed = 1;
        end else if (m_run != 0 && m_elapsed == DIV - 1) begin
            m_k = (m_k + 1) % PERIOD; m_elapsed = 0; m_changed = 1;
        end else if (m_run != 0) begin
            m_elapsed++;
        end
        if (wr_en && m_run == 0) m_buf[wr_addr] = wr_data;
        if (stop) m_run = 0;
        else if (start) m_run = 1;
        exp_vec = {win, 4'(pos_of(m_k)), m_run[0], strobe, werr};
    endfunction

    // One clock: model follows the inputs sampled at the edge, pulses drop afterwards.
    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
        start = 1'b0; stop = 1'b0; clear = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        checks++;
        if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL reset: got %h expected %h", dut_vec, exp_vec);
        end
        reset = 1'b0;
        cycle();
        checks++;
        if (dut_vec !== 23'd0) begin
            errors++;
            $display("FAIL reset_release: got %h expected 0", dut_vec);
        end
    endtask

    task automatic test_write_idle();
        for (int i = 0; i < MSG_LEN + 3; i++) begin
            if (i < MSG_LEN) begin
                wr_en = 1'b1; wr_addr = 4'(i); wr_data = 4'(i);
            end
            cycle();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL write_idle[%0d]: got %h expected %h", i, dut_vec, exp_vec);
            end
        end
        checks++;
        if ({char3, char2, char1, char0, busy, frame_strobe} !== {16'h0123, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL write_idle_window: got %h/%b%b expected 0123/00",
                     {char3, char2, char1, char0}, busy, frame_strobe);
        end
    endtask

    task automatic test_scroll();
        start = 1'b1;
        for (int i = 0; i < DIV * (MSG_LEN + 3); i++) begin
            cycle();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL scroll[%0d]: got %h expected %h", i, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_wr_err();
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'hA;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL wr_err[%0d]: got %h expected %h", i, dut_vec, exp_vec);
            end
        end
        stop = 1'b1; clear = 1'b1;
        cycle(); cycle();
        checks++;
        if (char3 !== 4'h0 || dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL wr_err_buffer: got %h expected %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_start_stop();
        int n;
        start = 1'b1;
        cycle();
        start = 1'b1; stop = 1'b1;
        cycle();
        checks++;
        if (busy !== 1'b0 || dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL start_stop_same: got %h expected %h", dut_vec, exp_vec);
        end
        start = 1'b1;
        n = 0;
        while (!(m_run != 0 && m_elapsed == 2) && n < 50) begin
            cycle(); n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL start_stop_timeout: got %0d cycles expected < 50", n);
        end
        stop = 1'b1;
        cycle();
        start = 1'b1;
        for (int i = 0; i < 2 * DIV + 2; i++) begin
            cycle();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL resume[%0d]: got %h expected %h", i, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_clear_tick();
        int n;
        stop = 1'b1; clear = 1'b1;
        cycle();
        start = 1'b1;
        n = 0;
        while (!(m_run != 0 && pos_of(m_k) == 7 && m_elapsed == DIV - 1) && n < 300) begin
            cycle(); n++;
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL clear_run[%0d]: got %h expected %h", n, dut_vec, exp_vec);
            end
        end
        if (n >= 300) begin
            errors++;
            $display("FAIL clear_tick_timeout: got %0d cycles expected < 300", n);
        end
        clear = 1'b1;
        cycle();
        checks++;
        if (pos !== 4'd0 || dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL clear_tick_pos: got %h expected %h", dut_vec, exp_vec);
        end
        cycle();
        checks++;
        if ({char3, char2, char1, char0, frame_strobe} !== {16'h0123, 1'b1} || dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL clear_tick_window: got %h expected %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 4'($urandom_range(0, 15));
            start   = ($urandom_range(0, 9) == 0);
            stop    = ($urandom_range(0, 19) == 0);
            clear   = ($urandom_range(0, 39) == 0);
            cycle();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", i, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1;
        for (int i = 0; i < 3 * DIV + 1; i++) cycle();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 23'd0) begin
            errors++;
            $display("FAIL reset_mid_run: got %h expected 0", dut_vec);
        end
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL after_reset[%0d]: got %h expected %h", i, dut_vec, exp_vec);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_idle();
        test_scroll();
        test_wr_err();
        test_start_stop();
        test_clear_tick();
        test_random();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
